// File: rtl/mt_prng_pkg.sv
// Shared Mersenne Twister constants (MT19937 / MT19937-64) selected by word width,
// plus the generator FSM state type.
package mt_prng_pkg;

  typedef enum logic {ST_SEED, ST_RUN} mt_state_e;

  localparam int MT_R = 31;

  function automatic int mt_n(input int w); return (w == 64) ? 312 : 624; endfunction
  function automatic int mt_m(input int w); return (w == 64) ? 156 : 397; endfunction
  function automatic int mt_u(input int w); return (w == 64) ? 29 : 11;   endfunction
  function automatic int mt_s(input int w); return (w == 64) ? 17 : 7;    endfunction
  function automatic int mt_t(input int w); return (w == 64) ? 37 : 15;   endfunction
  function automatic int mt_l(input int w); return (w == 64) ? 43 : 18;   endfunction

  function automatic logic [63:0] mt_a(input int w);
    return (w == 64) ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
  endfunction
  function automatic logic [63:0] mt_d(input int w);
    return (w == 64) ? 64'h5555_5555_5555_5555 : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] mt_b(input int w);
    return (w == 64) ? 64'h71D6_7FFF_EDA6_0000 : 64'h0000_0000_9D2C_5680;
  endfunction
  function automatic logic [63:0] mt_c(input int w);
    return (w == 64) ? 64'hFFF7_EEE0_0000_0000 : 64'h0000_0000_EFC6_0000;
  endfunction
  function automatic logic [63:0] mt_f(input int w);
    return (w == 64) ? 64'd6364136223846793005 : 64'd1812433253;
  endfunction

endpackage

// File: rtl/mt_prng_if.sv
// Seed control and ready/valid random-word stream between the generator and its consumer.
interface mt_prng_if #(parameter int W = 32);
  logic [W-1:0] seed_val;
  logic         seed_start;
  logic [W-1:0] r_num;
  logic         valid;
  logic         ready;
  logic         busy;

  modport master (output seed_val, seed_start, ready, input r_num, valid, busy);
  modport slave  (input seed_val, seed_start, ready, output r_num, valid, busy);
endinterface

// File: rtl/mt_temper.sv
// Combinational Mersenne Twister output tempering for a W-bit word.
module mt_temper
  import mt_prng_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  localparam int U = mt_u(W);
  localparam int S = mt_s(W);
  localparam int T = mt_t(W);
  localparam int L = mt_l(W);
  localparam logic [W-1:0] D = W'(mt_d(W));
  localparam logic [W-1:0] B = W'(mt_b(W));
  localparam logic [W-1:0] C = W'(mt_c(W));

  logic [W-1:0] y1, y2, y3;

  always_comb begin
    y1  = x_i ^ ((x_i >> U) & D);
    y2  = y1 ^ ((y1 << S) & B);
    y3  = y2 ^ ((y2 << T) & C);
    y_o = y3 ^ (y3 >> L);
  end
endmodule

// File: rtl/mt_prng.sv
// Parametrised Mersenne Twister: one-word-per-cycle seeding, then an in-place
// per-word twist feeding a backpressure-holding output register.
module mt_prng
  import mt_prng_pkg::*;
#(
  parameter int           W            = 32,
  parameter logic [W-1:0] DEFAULT_SEED = W'(5489)
) (
  input  logic     clk,
  input  logic     rst,
  mt_prng_if.slave bus
);
  if (W != 32 && W != 64) begin : g_bad_w
    $error("mt_prng: W must be 32 or 64");
  end

  localparam int N  = mt_n(W);
  localparam int M  = mt_m(W);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   M_X  = (IW+1)'(M);
  localparam logic [IW:0]   N_X  = (IW+1)'(N);
  localparam logic [W-1:0]  A    = W'(mt_a(W));
  localparam logic [W-1:0]  F    = W'(mt_f(W));

  logic [W-1:0]  mt_q [N];
  mt_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  seed_q, seed_d;   // seed, then the previous word written while seeding
  logic [W-1:0]  rnum_q, rnum_d;
  logic          valid_q, valid_d;

  logic          we;
  logic [W-1:0]  wdata;
  logic [IW-1:0] idx_p1, idx_m;
  logic [IW:0]   m_sum;
  logic [W-1:0]  rd_i, rd_p1, rd_m, y, x_new, tmp, seed_nxt;

  always_comb begin
    idx_p1 = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    m_sum  = {1'b0, idx_q} + M_X;
    idx_m  = (m_sum >= N_X) ? IW'(m_sum - N_X) : IW'(m_sum);
    rd_i   = mt_q[idx_q];
    rd_p1  = mt_q[idx_p1];
    rd_m   = mt_q[idx_m];
    y      = {rd_i[W-1:MT_R], rd_p1[MT_R-1:0]};
    x_new  = rd_m ^ (y >> 1) ^ (y[0] ? A : '0);
    seed_nxt = F * (seed_q ^ (seed_q >> (W - 2))) + W'(idx_q);
  end

  mt_temper #(.W(W)) u_temper (.x_i(x_new), .y_o(tmp));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    rnum_d  = rnum_q;
    valid_d = valid_q;
    we      = 1'b0;
    wdata   = x_new;
    if (bus.seed_start) begin
      // Abort anything in flight; the pending word is dropped
      state_d = ST_SEED;
      idx_d   = '0;
      seed_d  = bus.seed_val;
      valid_d = 1'b0;
    end else if (state_q == ST_SEED) begin
      we     = 1'b1;
      wdata  = (idx_q == '0) ? seed_q : seed_nxt;
      seed_d = wdata;
      if (idx_q == LAST) begin
        state_d = ST_RUN;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (!valid_q || bus.ready) begin
      we      = 1'b1;
      rnum_d  = tmp;
      valid_d = 1'b1;
      idx_d   = idx_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEED;
      idx_q   <= '0;
      seed_q  <= DEFAULT_SEED;
      rnum_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      rnum_q  <= rnum_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mt_q[idx_q] <= wdata;
  end

  assign bus.r_num = rnum_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == ST_SEED);
endmodule

// File: tb/tb_mt_prng.sv
// Bench for mt_prng: W=32 and W=64 instances checked against a batch-twist reference model.
module tb_mt_prng;
  logic        clk = 1'b0;
  logic        rst32 = 1'b1, rst64 = 1'b1;
  logic        rdy = 1'b1, sstart = 1'b0, sel64 = 1'b0;
  logic [63:0] sval = '0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mt_prng_if #(.W(32)) if32 ();
  mt_prng_if #(.W(64)) if64 ();

  assign if32.seed_val   = sval[31:0];
  assign if64.seed_val   = sval;
  assign if32.seed_start = sstart & ~sel64;
  assign if64.seed_start = sstart & sel64;
  assign if32.ready      = rdy;
  assign if64.ready      = rdy;

  mt_prng #(.W(32)) dut32 (.clk(clk), .rst(rst32), .bus(if32));
  mt_prng #(.W(64)) dut64 (.clk(clk), .rst(rst64), .bus(if64));

  logic [63:0] o_rnum;
  logic        o_valid, o_busy;
  assign o_rnum  = sel64 ? if64.r_num : {32'd0, if32.r_num};
  assign o_valid = sel64 ? if64.valid : if32.valid;
  assign o_busy  = sel64 ? if64.busy  : if32.busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: textbook MT with a full-table twist every n outputs
  logic [63:0] ms [624];
  int          mw, mn, mm, midx;

  function automatic logic [63:0] msk(input logic [63:0] v);
    return (mw == 64) ? v : (v & 64'hFFFF_FFFF);
  endfunction

  task automatic mdl_seed(input int w, input logic [63:0] s);
    logic [63:0] f;
    mw = w;
    mn = (w == 64) ? 312 : 624;
    mm = (w == 64) ? 156 : 397;
    f  = (w == 64) ? 64'd6364136223846793005 : 64'd1812433253;
    ms[0] = msk(s);
    for (int j = 1; j < mn; j++)
      ms[j] = msk(f * (ms[j-1] ^ (ms[j-1] >> (w - 2))) + 64'(j));
    midx = mn;
  endtask

  task automatic mdl_next(output logic [63:0] r);
    logic [63:0] y, a, up;
    a  = (mw == 64) ? 64'hB5026F5AA96619E9 : 64'h9908B0DF;
    up = msk(~64'h7FFF_FFFF);
    if (midx >= mn) begin
      for (int k = 0; k < mn; k++) begin
        y     = (ms[k] & up) | (ms[(k + 1) % mn] & 64'h7FFF_FFFF);
        ms[k] = ms[(k + mm) % mn] ^ (y >> 1) ^ (y[0] ? a : 64'd0);
      end
      midx = 0;
    end
    y = ms[midx];
    midx++;
    if (mw == 32) begin
      y ^= y >> 11;
      y ^= (y << 7) & 64'h9D2C5680;
      y ^= (y << 15) & 64'hEFC60000;
      y ^= y >> 18;
    end else begin
      y ^= (y >> 29) & 64'h5555555555555555;
      y ^= (y << 17) & 64'h71D67FFFEDA60000;
      y ^= (y << 37) & 64'hFFF7EEE000000000;
      y ^= y >> 43;
    end
    r = msk(y);
  endtask

  logic [63:0] got_w [3];
  logic [63:0] last_w;

  // Accept cnt words (random ready when rnd), checking each against the model and
  // that a stalled word stays put.
  task automatic take(input int cnt, input bit rnd);
    int          got = 0, cyc = 0;
    bit          hold = 0;
    logic [63:0] held, e;
    while (got < cnt && cyc < cnt * 6 + 100) begin
      if (hold) chk("hold", {o_valid, o_rnum[62:0]}, {1'b1, held[62:0]});
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && rdy) begin
        mdl_next(e);
        chk("word", o_rnum, e);
        if (got < 3) got_w[got] = o_rnum;
        last_w = o_rnum;
        got++;
      end
      hold = o_valid && !rdy;
      held = o_rnum;
      @(negedge clk);
      cyc++;
    end
    if (got < cnt) chk("take_timeout", 64'(got), 64'(cnt));
    rdy = 1'b1;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (o_busy && c < 3000) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_seed(input logic [63:0] v);
    sval = v;
    sstart = 1'b1;
    @(negedge clk);
    sstart = 1'b0;
  endtask

  initial begin
    int          c;
    logic [63:0] v;

    // W=32 reset and auto-seed
    repeat (2) @(negedge clk);
    chk("rst_rnum", o_rnum, 0);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_busy", 64'(o_busy), 1);
    rst32 = 1'b0;
    count_busy(c);
    chk("busy_len_auto", 64'(c), 624);
    chk("valid_after_busy", 64'(o_valid), 0);
    @(negedge clk);
    chk("first_valid", 64'(o_valid), 1);
    mdl_seed(32, 64'd5489);
    take(10000, 0);
    chk("auto_first", got_w[0], 64'd3499211612);
    chk("auto_10000", last_w, 64'd4123659995);

    // Reseed with 1 mid-stream
    pulse_seed(64'd1);
    chk("valid_drop", 64'(o_valid), 0);
    count_busy(c);
    chk("busy_len_s1", 64'(c), 624);
    mdl_seed(32, 64'd1);
    take(3, 0);
    chk("s1_w0", got_w[0], 64'd1791095845);
    chk("s1_w1", got_w[1], 64'd4282876139);
    chk("s1_w2", got_w[2], 64'd3093770124);

    // Random backpressure, then reseed after 700 words
    take(700, 1);
    v = 64'($urandom);
    pulse_seed(v);
    chk("valid_drop_700", 64'(o_valid), 0);
    count_busy(c);
    chk("busy_len_700", 64'(c), 624);
    mdl_seed(32, v);
    take(800, 1);

    // seed_start while seeding restarts with the newer seed
    pulse_seed(64'($urandom));
    repeat (100) @(negedge clk);
    pulse_seed(64'd1);
    count_busy(c);
    chk("busy_len_restart", 64'(c), 624);
    mdl_seed(32, 64'd1);
    take(20, 0);
    chk("restart_first", got_w[0], 64'd1791095845);

    // rst at seeding cycle 300 wins over a simultaneous seed_start
    pulse_seed(64'($urandom));
    repeat (299) @(negedge clk);
    rst32 = 1'b1;
    sstart = 1'b1;
    sval = 64'($urandom);
    @(negedge clk);
    chk("rst2_rnum", o_rnum, 0);
    chk("rst2_valid", 64'(o_valid), 0);
    chk("rst2_busy", 64'(o_busy), 1);
    rst32 = 1'b0;
    sstart = 1'b0;
    count_busy(c);
    chk("busy_len_rst2", 64'(c), 624);
    mdl_seed(32, 64'd5489);
    take(50, 1);
    chk("rst2_first", got_w[0], 64'd3499211612);

    // W=64 auto-seed
    rst32 = 1'b1;
    sel64 = 1'b1;
    @(negedge clk);
    chk("rst64_rnum", o_rnum, 0);
    chk("rst64_busy", 64'(o_busy), 1);
    rst64 = 1'b0;
    count_busy(c);
    chk("busy_len_64", 64'(c), 312);
    mdl_seed(64, 64'd5489);
    take(10000, 0);
    chk("w64_first", got_w[0], 64'd14514284786278117030);
    chk("w64_10000", last_w, 64'd9981545732273789042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
